// File: rtl/perf_window_sampler.sv
// Gated cycle/stall/mispredict counters cut into fixed windows; each window's snapshot is streamed
// as tagged words over valid/ready. Define PERF_MAX_STALL_EN to add a longest-stall-run word (tag 3).
module perf_window_sampler #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             stall,
    input  logic             branch_mispredict,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_data,
    output logic [1:0]       out_tag,
    output logic             out_last,
    output logic             running,
    output logic             overrun,
    output logic [15:0]      window_count
);
    typedef enum logic {S_IDLE, S_RUN} ctrl_e;
    typedef enum logic [2:0] {O_IDLE, O_CYC, O_STL, O_BR, O_MAX} out_e;

`ifdef PERF_MAX_STALL_EN
    localparam out_e O_LAST = O_MAX;
`else
    localparam out_e O_LAST = O_BR;
`endif
    localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    ctrl_e             ctrl_q, ctrl_d;
    out_e              ost_q, ost_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d, stl_q, stl_d, br_q, br_d;
    logic [CNT_W-1:0]  snap_cyc_q, snap_cyc_d, snap_stl_q, snap_stl_d, snap_br_q, snap_br_d;
    logic [CNT_W-1:0]  cyc_inc, stl_inc, br_inc;
    logic [15:0]       win_cnt_q, win_cnt_d;
    logic              overrun_q, overrun_d;
    logic              run, halt, win_end, fire, accept;

    // cyc_q doubles as the window position: it restarts at every window end or stop
    assign run     = (ctrl_q == S_RUN);
    assign halt    = run && stop && !start;
    assign win_end = run && !halt && !clear && (cyc_q == POS_LAST);
    assign fire    = out_valid && out_ready;
    assign accept  = win_end && ((ost_q == O_IDLE) || (fire && ost_q == O_LAST));

    always_comb begin
        ctrl_d = ctrl_q;
        if (ctrl_q == S_IDLE && start && !stop)
            ctrl_d = S_RUN;
        else if (halt)
            ctrl_d = S_IDLE;
    end

    always_comb begin
        cyc_inc    = cyc_q + ONE;
        stl_inc    = stl_q + CNT_W'(stall);
        br_inc     = br_q + CNT_W'(branch_mispredict);
        cyc_d      = cyc_q;
        stl_d      = stl_q;
        br_d       = br_q;
        snap_cyc_d = snap_cyc_q;
        snap_stl_d = snap_stl_q;
        snap_br_d  = snap_br_q;
        if (clear || halt || win_end) begin
            cyc_d = '0;
            stl_d = '0;
            br_d  = '0;
        end else if (run) begin
            cyc_d = cyc_inc;
            stl_d = stl_inc;
            br_d  = br_inc;
        end
        if (accept) begin
            snap_cyc_d = cyc_inc;
            snap_stl_d = stl_inc;
            snap_br_d  = br_inc;
        end
        win_cnt_d = clear ? 16'd0 : win_cnt_q + 16'(win_end);
        overrun_d = !clear && (overrun_q || (win_end && !accept));
    end

`ifdef PERF_MAX_STALL_EN
    logic [CNT_W-1:0] srun_q, srun_d, smax_q, smax_d, snap_max_q, snap_max_d;
    logic [CNT_W-1:0] srun_inc, smax_inc;

    always_comb begin
        srun_inc   = stall ? srun_q + ONE : '0;
        smax_inc   = (srun_inc > smax_q) ? srun_inc : smax_q;
        srun_d     = srun_q;
        smax_d     = smax_q;
        snap_max_d = snap_max_q;
        if (clear || halt || win_end) begin
            srun_d = '0;
            smax_d = '0;
        end else if (run) begin
            srun_d = srun_inc;
            smax_d = smax_inc;
        end
        if (accept)
            snap_max_d = smax_inc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            srun_q     <= '0;
            smax_q     <= '0;
            snap_max_q <= '0;
        end else begin
            srun_q     <= srun_d;
            smax_q     <= smax_d;
            snap_max_q <= snap_max_d;
        end
    end
`endif

    // A fresh capture takes priority over the final-word advance so back-to-back streams have no gap
    always_comb begin
        ost_d = ost_q;
        if (clear)
            ost_d = O_IDLE;
        else if (accept)
            ost_d = O_CYC;
        else if (fire) begin
            unique case (ost_q)
                O_CYC:   ost_d = O_STL;
                O_STL:   ost_d = O_BR;
                O_BR:    ost_d = (O_LAST == O_BR) ? O_IDLE : O_MAX;
                default: ost_d = O_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (ost_q != O_IDLE);
        out_last  = (ost_q == O_LAST);
        out_tag   = 2'd0;
        out_data  = '0;
        unique case (ost_q)
            O_CYC: out_data = snap_cyc_q;
            O_STL: begin out_tag = 2'd1; out_data = snap_stl_q; end
            O_BR:  begin out_tag = 2'd2; out_data = snap_br_q;  end
`ifdef PERF_MAX_STALL_EN
            O_MAX: begin out_tag = 2'd3; out_data = snap_max_q; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= S_IDLE;
            ost_q      <= O_IDLE;
            cyc_q      <= '0;
            stl_q      <= '0;
            br_q       <= '0;
            snap_cyc_q <= '0;
            snap_stl_q <= '0;
            snap_br_q  <= '0;
            win_cnt_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            ost_q      <= ost_d;
            cyc_q      <= cyc_d;
            stl_q      <= stl_d;
            br_q       <= br_d;
            snap_cyc_q <= snap_cyc_d;
            snap_stl_q <= snap_stl_d;
            snap_br_q  <= snap_br_d;
            win_cnt_q  <= win_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign running      = run;
    assign overrun      = overrun_q;
    assign window_count = win_cnt_q;
endmodule

// File: tb/tb_perf_window_sampler.sv
// Directed bench for perf_window_sampler at WINDOW_CYCLES=16; follows PERF_MAX_STALL_EN if defined.
`timescale 1ns/1ps
module tb_perf_window_sampler;
    localparam int WIN = 16;
    localparam int CW  = 32;
`ifdef PERF_MAX_STALL_EN
    localparam int NWORDS = 4;
`else
    localparam int NWORDS = 3;
`endif
    localparam logic BR_LAST = (NWORDS == 3);

    logic          clk = 1'b0;
    logic          rst_n, start, stop, clear, stall, branch_mispredict, out_ready;
    logic          out_valid, out_last, running, overrun;
    logic [CW-1:0] out_data;
    logic [1:0]    out_tag;
    logic [15:0]   window_count;
    logic [35:0]   obs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    assign obs = {out_valid, out_tag, out_last, out_data};

    perf_window_sampler #(.WINDOW_CYCLES(WIN), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .stall(stall), .branch_mispredict(branch_mispredict),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_last(out_last), .running(running),
        .overrun(overrun), .window_count(window_count)
    );

    // Expected word as {valid, tag, last, data}
    function automatic logic [35:0] w(input int tag, input logic last, input int data);
        return {1'b1, tag[1:0], last, data[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        stall = 1'b0; branch_mispredict = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One full window starting at position 0; bit p of each mask drives the event at position p
    task automatic run_window(input logic [15:0] stl_m, input logic [15:0] br_m);
        for (int p = 0; p < WIN; p++) begin
            stall = stl_m[p];
            branch_mispredict = br_m[p];
            tick();
        end
        stall = 1'b0;
        branch_mispredict = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1;
        do_reset();
        start = 1'b0;
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset_running got %b want 0", running); end
        vectors++; if ({out_valid, out_last, out_tag} !== 4'b0) begin miscompares++; $display("FAIL reset_out got v%b l%b t%0d want 0", out_valid, out_last, out_tag); end
        vectors++; if (window_count !== 16'd0) begin miscompares++; $display("FAIL reset_wincnt got %0d want 0", window_count); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        do_start();
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL basic_running got %b want 1", running); end
        run_window(16'h003C, 16'h0200);
        vectors++; if (obs !== w(0, 0, 16)) begin miscompares++; $display("FAIL basic_cyc got %h want %h", obs, w(0, 0, 16)); end
        vectors++; if (window_count !== 16'd1) begin miscompares++; $display("FAIL basic_wincnt got %0d want 1", window_count); end
        tick();
        vectors++; if (obs !== w(1, 0, 4)) begin miscompares++; $display("FAIL basic_stl got %h want %h", obs, w(1, 0, 4)); end
        tick();
        vectors++; if (obs !== w(2, BR_LAST, 1)) begin miscompares++; $display("FAIL basic_br got %h want %h", obs, w(2, BR_LAST, 1)); end
`ifdef PERF_MAX_STALL_EN
        tick();
        vectors++; if (obs !== w(3, 1, 4)) begin miscompares++; $display("FAIL basic_max got %h want %h", obs, w(3, 1, 4)); end
`endif
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_idle got %b want 0", out_valid); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        do_start();
        run_window(16'h0007, 16'h0000);
        vectors++; if (obs !== w(0, 0, 16)) begin miscompares++; $display("FAIL hold_first got %h want %h", obs, w(0, 0, 16)); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (obs !== w(0, 0, 16)) begin miscompares++; $display("FAIL hold_%0d got %h want %h", i, obs, w(0, 0, 16)); end
        end
        out_ready = 1'b1;
        tick();
        vectors++; if (obs !== w(1, 0, 3)) begin miscompares++; $display("FAIL hold_stl got %h want %h", obs, w(1, 0, 3)); end
        tick();
        vectors++; if (obs !== w(2, BR_LAST, 0)) begin miscompares++; $display("FAIL hold_br got %h want %h", obs, w(2, BR_LAST, 0)); end
`ifdef PERF_MAX_STALL_EN
        tick();
        vectors++; if (obs !== w(3, 1, 3)) begin miscompares++; $display("FAIL hold_max got %h want %h", obs, w(3, 1, 3)); end
`endif
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_idle got %b want 0", out_valid); end
    endtask

    task automatic test_overrun();
        do_reset();
        do_start();
        run_window(16'h0080, 16'h0000);
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_pre got %b want 0", overrun); end
        for (int i = 0; i < 20; i++) tick();
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", overrun); end
        vectors++; if (window_count !== 16'd2) begin miscompares++; $display("FAIL ovr_wincnt got %0d want 2", window_count); end
        vectors++; if (obs !== w(0, 0, 16)) begin miscompares++; $display("FAIL ovr_cyc got %h want %h", obs, w(0, 0, 16)); end
        out_ready = 1'b1;
        tick();
        vectors++; if (obs !== w(1, 0, 1)) begin miscompares++; $display("FAIL ovr_stl got %h want %h", obs, w(1, 0, 1)); end
        tick();
        vectors++; if (obs !== w(2, BR_LAST, 0)) begin miscompares++; $display("FAIL ovr_br got %h want %h", obs, w(2, BR_LAST, 0)); end
`ifdef PERF_MAX_STALL_EN
        tick();
        vectors++; if (obs !== w(3, 1, 1)) begin miscompares++; $display("FAIL ovr_max got %h want %h", obs, w(3, 1, 1)); end
`endif
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_idle got %b want 0", out_valid); end
    endtask

    // Final-word handshake lands exactly on the next window end
    task automatic test_back_to_back();
        do_reset();
        do_start();
        run_window(16'h0001, 16'h0001);
        vectors++; if (obs !== w(0, 0, 16)) begin miscompares++; $display("FAIL b2b_first got %h want %h", obs, w(0, 0, 16)); end
        for (int i = 1; i <= WIN; i++) begin
            out_ready = (i > WIN - NWORDS);
            tick();
        end
        vectors++; if (obs !== w(0, 0, 16)) begin miscompares++; $display("FAIL b2b_cyc got %h want %h", obs, w(0, 0, 16)); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun got %b want 0", overrun); end
        vectors++; if (window_count !== 16'd2) begin miscompares++; $display("FAIL b2b_wincnt got %0d want 2", window_count); end
        tick();
        vectors++; if (obs !== w(1, 0, 0)) begin miscompares++; $display("FAIL b2b_stl got %h want %h", obs, w(1, 0, 0)); end
    endtask

    task automatic test_stop();
        logic seen;
        do_reset();
        out_ready = 1'b1;
        do_start();
        for (int p = 0; p < 10; p++) begin
            stall = (p < 3);
            start = (p == 5);
            stop  = (p == 5);
            tick();
            if (p == 5) begin
                vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL stop_both got %b want 1", running); end
            end
        end
        stall = 1'b0; start = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL stop_running got %b want 0", running); end
        seen = out_valid;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= out_valid;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL stop_words got %b want 0", seen); end
        vectors++; if (window_count !== 16'd0) begin miscompares++; $display("FAIL stop_wincnt got %0d want 0", window_count); end
        do_start();
        run_window(16'h0010, 16'h0000);
        vectors++; if (obs !== w(0, 0, 16)) begin miscompares++; $display("FAIL stop_cyc got %h want %h", obs, w(0, 0, 16)); end
        tick();
        vectors++; if (obs !== w(1, 0, 1)) begin miscompares++; $display("FAIL stop_stl got %h want %h", obs, w(1, 0, 1)); end
    endtask

    task automatic test_clear();
        do_reset();
        do_start();
        run_window(16'h0000, 16'h0000);
        for (int i = 0; i < 20; i++) tick();
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL clr_pre got %b want 1", overrun); end
        out_ready = 1'b1;
        tick();
        vectors++; if (obs !== w(1, 0, 0)) begin miscompares++; $display("FAIL clr_stl got %h want %h", obs, w(1, 0, 0)); end
        out_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_valid got %b want 0", out_valid); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL clr_overrun got %b want 0", overrun); end
        vectors++; if (window_count !== 16'd0) begin miscompares++; $display("FAIL clr_wincnt got %0d want 0", window_count); end
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL clr_running got %b want 1", running); end
        run_window(16'h0000, 16'h0000);
        vectors++; if (obs !== w(0, 0, 16)) begin miscompares++; $display("FAIL clr_next got %h want %h", obs, w(0, 0, 16)); end
        vectors++; if (window_count !== 16'd1) begin miscompares++; $display("FAIL clr_wincnt2 got %0d want 1", window_count); end
    endtask

    task automatic test_max_stall();
        do_reset();
        out_ready = 1'b1;
        do_start();
        run_window(16'h07CE, 16'h0000);
        vectors++; if (obs !== w(0, 0, 16)) begin miscompares++; $display("FAIL max_cyc got %h want %h", obs, w(0, 0, 16)); end
        tick();
        vectors++; if (obs !== w(1, 0, 8)) begin miscompares++; $display("FAIL max_stl got %h want %h", obs, w(1, 0, 8)); end
        tick();
        vectors++; if (obs !== w(2, BR_LAST, 0)) begin miscompares++; $display("FAIL max_br got %h want %h", obs, w(2, BR_LAST, 0)); end
`ifdef PERF_MAX_STALL_EN
        tick();
        vectors++; if (obs !== w(3, 1, 5)) begin miscompares++; $display("FAIL max_run got %h want %h", obs, w(3, 1, 5)); end
`endif
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL max_idle got %b want 0", out_valid); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall_hold();
        test_overrun();
        test_back_to_back();
        test_stop();
        test_clear();
        test_max_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
